// File: rtl/gray_codec_pkg.sv
// Shared constants and width-generic Gray/binary helpers for the Gray/binary codec pipeline.
// The helpers work on a fixed wide word; callers zero-extend narrower data.
package gray_codec_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;
    localparam int   MAX_W    = 64;

    function automatic int chunk_size(input int width, input int stages);
        return (width + stages - 32'sd1) / stages;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result unaffected.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = g;
        for (int s = 1; s < MAX_W; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] x);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < MAX_W; i++) begin
            cnt = cnt + 32'(x[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline register of the Gray/binary codec: valid bit, mode/err tags and a data word.
// The word holds already-resolved binary bits above this stage's chunk and raw Gray bits below it.
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             up_valid,
    input  logic             up_mode,
    input  logic             up_err,
    input  logic [WIDTH-1:0] up_word,
    output logic             valid,
    output logic             mode,
    output logic             err,
    output logic [WIDTH-1:0] word
);

    localparam int CHUNK = chunk_size(WIDTH, STAGES);
    localparam int HI    = WIDTH - 1 - IDX * CHUNK;
    localparam int LO    = ((WIDTH - (IDX + 1) * CHUNK) > 0) ? (WIDTH - (IDX + 1) * CHUNK) : 0;

    logic             valid_r;
    logic             mode_r;
    logic             err_r;
    logic [WIDTH-1:0] word_r;
    logic [WIDTH-1:0] word_nxt_s;

    // Resolve this stage's chunk of the Gray prefix XOR; binary->Gray words pass through untouched.
    always_comb begin
        logic [WIDTH-1:0] acc;
        acc = up_word;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if ((up_mode == MODE_G2B) && (i <= HI) && (i >= LO)) begin
                acc[i] = acc[i+1] ^ up_word[i];
            end else begin
                acc[i] = up_word[i];
            end
        end
        word_nxt_s = acc;
    end

    // Stage register: takes a new beat (or a bubble) whenever the stage advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            mode_r  <= 1'b0;
            err_r   <= 1'b0;
            word_r  <= {WIDTH{1'b0}};
        end else if (adv) begin
            valid_r <= up_valid;
            if (up_valid) begin
                mode_r <= up_mode;
                err_r  <= up_err;
                word_r <= word_nxt_s;
            end
        end
    end

    assign valid = valid_r;
    assign mode  = mode_r;
    assign err   = err_r;
    assign word  = word_r;

endmodule

// File: rtl/gray_bin_codec_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides and a
// single-bit-step checker on the Gray->binary stream.
module gray_bin_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_step_err
);

    logic             stg_valid_s [STAGES];
    logic             stg_mode_s  [STAGES];
    logic             stg_err_s   [STAGES];
    logic [WIDTH-1:0] stg_word_s  [STAGES];
    logic             up_valid_s  [STAGES];
    logic             up_mode_s   [STAGES];
    logic             up_err_s    [STAGES];
    logic [WIDTH-1:0] up_word_s   [STAGES];

    logic [STAGES-1:0] adv_s;
    logic              accept_s;
    logic              step_err_s;
    logic [WIDTH-1:0]  in_word_s;
    logic              first_flag_r;
    logic [WIDTH-1:0]  prev_gray_r;

    // Ready chain from the output back to the input: a stage moves if it is empty or its successor moves.
    always_comb begin
        logic [STAGES-1:0] chain;
        chain = {STAGES{1'b0}};
        chain[STAGES-1] = !stg_valid_s[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            chain[k] = !stg_valid_s[k] || chain[k+1];
        end
        adv_s = chain;
    end

    assign in_ready = adv_s[0];
    assign accept_s = in_valid && adv_s[0];

    // Step check against the last accepted Gray->binary beat.
    always_comb begin
        if ((in_mode == MODE_G2B) && !first_flag_r) begin
            step_err_s = (popcount(MAX_W'(in_data ^ prev_gray_r)) != 32'd1);
        end else begin
            step_err_s = 1'b0;
        end
    end

    // Binary->Gray is finished at entry; Gray->binary enters raw and is resolved chunk by chunk.
    always_comb begin
        if (in_mode == MODE_B2G) begin
            in_word_s = WIDTH'(bin2gray(MAX_W'(in_data)));
        end else begin
            in_word_s = in_data;
        end
    end

    // Step-checker history, touched only by accepted Gray->binary beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_flag_r <= 1'b1;
            prev_gray_r  <= {WIDTH{1'b0}};
        end else if (accept_s && (in_mode == MODE_G2B)) begin
            first_flag_r <= 1'b0;
            prev_gray_r  <= in_data;
        end
    end

    // Feed each stage from its predecessor, stage 0 from the input port.
    always_comb begin
        up_valid_s[0] = in_valid;
        up_mode_s[0]  = in_mode;
        up_err_s[0]   = step_err_s;
        up_word_s[0]  = in_word_s;
        for (int k = 1; k < STAGES; k++) begin
            up_valid_s[k] = stg_valid_s[k-1];
            up_mode_s[k]  = stg_mode_s[k-1];
            up_err_s[k]   = stg_err_s[k-1];
            up_word_s[k]  = stg_word_s[k-1];
        end
    end

    for (genvar ks = 0; ks < STAGES; ks++) begin : g_stage
        gray_codec_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .IDX   (ks)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv_s[ks]),
            .up_valid(up_valid_s[ks]),
            .up_mode (up_mode_s[ks]),
            .up_err  (up_err_s[ks]),
            .up_word (up_word_s[ks]),
            .valid   (stg_valid_s[ks]),
            .mode    (stg_mode_s[ks]),
            .err     (stg_err_s[ks]),
            .word    (stg_word_s[ks])
        );
    end

    assign out_valid    = stg_valid_s[STAGES-1];
    assign out_mode     = stg_mode_s[STAGES-1];
    assign out_step_err = stg_err_s[STAGES-1];
    assign out_data     = stg_word_s[STAGES-1];

endmodule

// File: doc/gray_bin_codec_pipe.md
Name: gray_bin_codec_pipe

Overview:
- Parametrised, pipelined, bidirectional Gray/binary converter with valid/ready handshakes on both sides.
- Each input beat selects its own direction: Gray->binary or binary->Gray.
- In Gray->binary mode, each beat is also checked for a legal single-bit step against the previous Gray->binary beat.
- Sits between Gray-coded sources (async-FIFO pointers, encoders) and binary arithmetic consumers.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- STAGES, 2, pipeline depth and latency in cycles (1..WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the input beat this cycle.
- in_mode  input  1  0 = Gray->binary, 1 = binary->Gray.
- in_data  input  WIDTH  input code word.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the output beat.
- out_mode  output  1  mode tag carried with the beat.
- out_data  output  WIDTH  converted word.
- out_step_err  output  1  Gray step violation; valid only with out_valid and out_mode=0.

Behaviour:
- Reset (async assert, sync release):
  - All stage valids = 0, so out_valid = 0.
  - out_data = 0, out_mode = 0, out_step_err = 0.
  - Step checker history is cleared: first_flag = 1, prev_gray = 0.
- Handshake rules:
  - A beat is accepted when in_valid && in_ready.
  - A beat is delivered when out_valid && out_ready.
  - in_data and in_mode are sampled only on acceptance.
  - out_data, out_mode and out_step_err hold stable while out_valid && !out_ready.
- Pipeline:
  - STAGES register stages, each with its own valid bit.
  - Stage k advances if it is empty or stage k+1 advances. The last stage advances if it is empty or out_ready is high.
  - in_ready = !v0 || stage0 advances. This is a combinational ready chain; no bubbles are permitted.
  - With no stall, a beat accepted on edge N appears on out_valid after edge N+STAGES-1 (latency = STAGES cycles).
  - Throughput is 1 beat/cycle. Order is preserved across mixed modes.
- Gray->binary arithmetic:
  - b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - The XOR prefix is split MSB-first into chunks of ceil(WIDTH/STAGES) bits, one chunk resolved per stage.
  - Each stage carries the partial binary result and the remaining Gray bits.
- Binary->Gray arithmetic:
  - g = b ^ (b >> 1), computed in stage 0.
  - The result is then delayed through the remaining stages so latency equals the Gray->binary path.
- Step checker (evaluated at acceptance, result carried through the pipe as a tag):
  - Applies only to mode-0 beats.
  - err = !first_flag && (popcount(in_data ^ prev_gray) != 1).
  - On each mode-0 acceptance: prev_gray <= in_data, first_flag <= 0.
  - Mode-1 beats neither update nor consult the history, and carry err = 0.
  - Repeating the same Gray value (distance 0) is an error.
  - Wrap-around (e.g. WIDTH=4: 1000 -> 0000) is a legal step.
- Simultaneous acceptance and delivery in the same cycle is legal when full; occupancy is unchanged.
- Reset mid-operation discards all in-flight beats immediately and clears the checker history.
- STAGES=1: a single register. in_ready = !v0 || out_ready.

Decomposition:
- Package gray_codec_pkg holds:
  - localparam MODE_G2B = 1'b0, MODE_B2G = 1'b1.
  - function gray2bin(width-generic).
  - function bin2gray.
  - function popcount.
  - Chunk-size constant computation (ceil(WIDTH/STAGES)).
- One natural sub-module, gray_codec_stage: a single pipeline register with valid/advance logic, partial-result/remaining-bit fields, and mode/err tag. It is instantiated STAGES times via generate.

Test Plan (WIDTH=4, STAGES=2 unless noted):
- Gray sweep: mode 0, out_ready=1, feed the Gray sequence of 0..15 (0000, 0001, 0011, ..., 1000) back-to-back -> out_data 0..15 in order, first out_valid 2 cycles after the first accept, all out_step_err = 0, 16 beats in 16 consecutive cycles.
- Binary->Gray: mode 1, in_data 4'd10 -> out_data 4'b1111. Then in_data 4'd15 -> 4'b1000. out_step_err = 0 for both.
- Step error: mode 0, feed 0000 then 0011 then 0011 -> out_step_err 0, 1, 1. Then 1000 after 1001 -> err 0.
- Backpressure: hold out_ready=0 while streaming -> at most 2 beats accepted, then in_ready = 0 and out_data stable. Release out_ready -> beats delivered in order with no loss or duplication.
- Mixed modes: alternate mode 0 (Gray 0110) and mode 1 (binary 0110) -> out 0100/mode0, then 0101/mode1. Checker history is unaffected by mode-1 beats.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid = 0 immediately. After release, first mode-0 beat 1111 gives out_step_err = 0. Repeat with STAGES=1 and STAGES=4, WIDTH=8: Gray 8'b11000000 -> 8'b10000000.
